// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter sweep sequencer.
package counter_pkg;

  localparam int N_DEFAULT     = 8;
  localparam int REP_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_UP   = 3'd2,
    ST_DOWN = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/counter_sweep_ctrl_sva.sv
// Protocol properties for counter_sweep_ctrl, attached to every instance through bind.
module counter_sweep_ctrl_sva (
  input logic clk,
  input logic rst,
  input logic en,
  input logic load,
  input logic done,
  input logic err,
  input logic accept,
  input logic saw_end
);

  a_load_implies_en : assert property (@(posedge clk) disable iff (rst) load |-> en);

  a_load_source : assert property (@(posedge clk) disable iff (rst)
    load |-> ($past(accept) || $past(saw_end)));

  a_done_err_excl : assert property (@(posedge clk) !(done && err));

endmodule

bind counter_sweep_ctrl counter_sweep_ctrl_sva u_sva (
  .clk    (i_clk),
  .rst    (i_rst),
  .en     (o_en),
  .load   (o_load),
  .done   (o_done),
  .err    (o_err),
  .accept (accept),
  .saw_end(saw_end)
);

// File: rtl/sweep_rep_counter.sv
// Remaining-periods counter: zero means run forever, one means this is the final period.
module sweep_rep_counter
  import counter_pkg::*;
#(
  parameter int REP_W = REP_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [REP_W-1:0] load_value,
  input  logic             dec,
  output logic             infinite,
  output logic             last
);

  logic [REP_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign infinite = (count == '0);
  assign last     = (count == REP_W'(1));

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Drives an up/down counter through sawtooth or triangle sweeps and checks its result
// against a locally tracked expected value.
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int REP_W = REP_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [N-1:0]     i_cmd_lo,
  input  logic [N-1:0]     i_cmd_hi,
  input  logic             i_cmd_tri,
  input  logic [REP_W-1:0] i_cmd_reps,
  input  logic             i_hold,
  input  logic             i_abort,
  input  logic [N-1:0]     i_result,
  output logic             o_en,
  output logic             o_load,
  output logic             o_dir,
  output logic [N-1:0]     o_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output state_t           o_state
);

  state_t       state, state_n;
  logic [N-1:0] lo_r, hi_r, expected, exp_n;
  logic         tri_r, err_r;
  logic         accept, reject, mismatch, period_end, saw_end;
  logic         en_c, load_c, dir_c, done_c;
  logic         rep_dec, rep_infinite, rep_last;

  // Command handshake: a command transfers on a cycle where i_cmd_valid and o_cmd_ready are
  // both high; ready is high only in IDLE outside reset, and valid needs no stability rule.
  assign o_cmd_ready = (state == ST_IDLE) && !i_rst;

  always_comb begin
    state_n    = state;
    exp_n      = expected;
    accept     = 1'b0;
    reject     = 1'b0;
    mismatch   = 1'b0;
    period_end = 1'b0;
    en_c       = 1'b0;
    load_c     = 1'b0;
    dir_c      = 1'b0;
    done_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          if (i_cmd_lo < i_cmd_hi) begin
            accept  = 1'b1;
            state_n = ST_LOAD;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (i_abort) begin
          state_n = ST_IDLE;
        end else begin
          en_c    = 1'b1;
          load_c  = 1'b1;
          exp_n   = lo_r;
          state_n = ST_UP;
        end
      end
      ST_UP: begin
        if (i_abort) begin
          state_n = ST_IDLE;
        end else if (i_result != expected) begin
          mismatch = 1'b1;
          state_n  = ST_IDLE;
        end else if (i_hold) begin
          state_n = ST_UP;
        end else if (i_result != hi_r) begin
          en_c  = 1'b1;
          dir_c = 1'b1;
          exp_n = expected + 1'b1;
        end else if (tri_r) begin
          state_n = ST_DOWN;
        end else begin
          period_end = 1'b1;
        end
      end
      ST_DOWN: begin
        if (i_abort) begin
          state_n = ST_IDLE;
        end else if (i_result != expected) begin
          mismatch = 1'b1;
          state_n  = ST_IDLE;
        end else if (i_hold) begin
          state_n = ST_DOWN;
        end else if (i_result != lo_r) begin
          en_c  = 1'b1;
          exp_n = expected - 1'b1;
        end else begin
          period_end = 1'b1;
        end
      end
      ST_DONE: begin
        done_c  = !i_abort;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    // A triangle ends its period at lo, where the counter already sits, so no reload is needed.
    if (period_end) begin
      if (rep_last) begin
        state_n = ST_DONE;
      end else begin
        state_n = tri_r ? ST_UP : ST_LOAD;
      end
    end
  end

  assign rep_dec = period_end && !rep_last && !rep_infinite;
  assign saw_end = period_end && !rep_last && !tri_r;

  sweep_rep_counter #(.REP_W(REP_W)) u_reps (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (accept),
    .load_value(i_cmd_reps),
    .dec       (rep_dec),
    .infinite  (rep_infinite),
    .last      (rep_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      expected <= '0;
      err_r    <= 1'b0;
      lo_r     <= '0;
      hi_r     <= '0;
      tri_r    <= 1'b0;
    end else begin
      state    <= state_n;
      expected <= exp_n;
      err_r    <= reject || mismatch;
      if (accept) begin
        lo_r  <= i_cmd_lo;
        hi_r  <= i_cmd_hi;
        tri_r <= i_cmd_tri;
      end
    end
  end

  assign o_en    = en_c && !i_rst;
  assign o_load  = load_c && !i_rst;
  assign o_dir   = dir_c && !i_rst;
  assign o_data  = (load_c && !i_rst) ? lo_r : '0;
  assign o_busy  = ((state == ST_LOAD) || (state == ST_UP) || (state == ST_DOWN)) && !i_rst;
  assign o_done  = done_c && !i_rst;
  assign o_err   = err_r && !i_rst;
  assign o_state = i_rst ? ST_IDLE : state;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: ideal counter model on i_result, position-based sweep model.
module tb_counter_sweep_ctrl;
  import counter_pkg::*;

  localparam int N     = 8;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_tri, hold, abort;
  logic [N-1:0]     cmd_lo, cmd_hi, result, data;
  logic [REP_W-1:0] cmd_reps;
  logic             en, load, dir, busy, done, err;
  state_t           state;

  logic [N-1:0]     cnt;
  logic             force_en;
  logic [N-1:0]     force_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_sweep_ctrl #(.N(N), .REP_W(REP_W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_lo   (cmd_lo),
    .i_cmd_hi   (cmd_hi),
    .i_cmd_tri  (cmd_tri),
    .i_cmd_reps (cmd_reps),
    .i_hold     (hold),
    .i_abort    (abort),
    .i_result   (result),
    .o_en       (en),
    .o_load     (load),
    .o_dir      (dir),
    .o_data     (data),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_state    (state)
  );

  // Ideal counter with a one-cycle registered result.
  always @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (en) cnt <= load ? data : (dir ? cnt + 8'd1 : cnt - 8'd1);
  end
  assign result = force_en ? force_val : cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic [N-1:0] lo, input logic [N-1:0] hi, input logic tri_m,
                      input logic [REP_W-1:0] reps);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_lo    = lo;
    cmd_hi    = hi;
    cmd_tri   = tri_m;
    cmd_reps  = reps;
    #1 chk("cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cnt(input logic [N-1:0] v, input int lim, input string tag);
    int k = 0;
    while (cnt !== v && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, cnt, v);
  endtask

  // Sweep model in "positions": each position is one cycle of an unstalled sweep;
  // a hold outside LOAD keeps the position, everything else advances it.
  task automatic run_sweep(input logic [N-1:0] lo, input logic [N-1:0] hi, input logic tri_m,
                           input logic [REP_W-1:0] reps, input int hold_pct);
    logic [N-1:0] exp_q[$];
    int d, done_pos, t, c, holds;
    logic is_ld, is_ck, h;
    d = int'(hi) - int'(lo);
    for (int r = 0; r < int'(reps); r++) begin
      for (int v = int'(lo); v <= int'(hi); v++) exp_q.push_back(N'(v));
      if (tri_m) for (int v = int'(hi); v >= int'(lo); v--) exp_q.push_back(N'(v));
    end
    done_pos = tri_m ? int'(reps) * (2 * d + 2) + 2 : int'(reps) * (d + 2) + 1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_lo    = lo;
    cmd_hi    = hi;
    cmd_tri   = tri_m;
    cmd_reps  = reps;
    #1 chk("accept_ready", cmd_ready, 1);
    chk("accept_no_load", load, 0);
    t = 1;
    c = 0;
    holds = 0;
    while (t <= done_pos && c < 3000) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      c++;
      is_ld = (t < done_pos) && (tri_m ? (t == 1) : (((t - 1) % (d + 2)) == 0));
      is_ck = (t < done_pos) && !is_ld;
      h = (is_ld || is_ck) && (holds < 8) && ($urandom_range(99) < 32'(hold_pct));
      hold = h;
      #1;
      chk("load", load, 32'(is_ld));
      if (is_ld) chk("load_data", data, lo);
      else chk("data_zero", data, 0);
      chk("done", done, 32'(t == done_pos));
      chk("busy", busy, 32'(t < done_pos));
      chk("no_err", err, 0);
      if (is_ck && h) chk("hold_en", en, 0);
      if (is_ck && !h) chk("trace", result, exp_q.pop_front());
      if (is_ld || !h) t++;
      if (h) holds++;
    end
    hold = 1'b0;
    chk("sweep_in_time", 32'(c < 3000), 1);
    chk("trace_left", exp_q.size(), 0);
    @(negedge clk);
    #1 chk("idle_after_done", state, ST_IDLE);
    chk("ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_lo = '0; cmd_hi = '0; cmd_tri = 1'b0; cmd_reps = '0;
    hold = 1'b0; abort = 1'b0; force_en = 1'b0; force_val = '0;

    // Reset: outputs silent even with a valid command presented.
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1; cmd_lo = 8'd1; cmd_hi = 8'd2;
    #1 chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_state", state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    #1 chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_err", err, 0);
    chk("post_rst_done", done, 0);

    // Directed sweeps from the plan, then the width boundaries.
    run_sweep(8'd2, 8'd5, 1'b0, 4'd1, 0);
    run_sweep(8'd0, 8'd3, 1'b1, 4'd2, 0);
    run_sweep(8'd2, 8'd5, 1'b0, 4'd2, 0);
    run_sweep(8'd0, 8'd255, 1'b0, 4'd1, 0);
    run_sweep(8'd250, 8'd255, 1'b1, 4'd2, 20);

    // Rejected commands: lo == hi and lo > hi.
    send(8'd7, 8'd7, 1'b0, 4'd1);
    #1 chk("rej_err", err, 1);
    chk("rej_load", load, 0);
    chk("rej_state", state, ST_IDLE);
    @(negedge clk);
    #1 chk("rej_err_pulse", err, 0);
    send(8'd9, 8'd3, 1'b1, 4'd1);
    #1 chk("rej2_err", err, 1);
    chk("rej2_busy", busy, 0);

    // Mismatch at expected=4.
    send(8'd0, 8'd9, 1'b0, 4'd0);
    wait_cnt(8'd4, 30, "mm_reach");
    force_en = 1'b1; force_val = 8'd6;
    #1 chk("mm_en", en, 0);
    @(negedge clk);
    force_en = 1'b0;
    #1 chk("mm_err", err, 1);
    chk("mm_state", state, ST_IDLE);
    chk("mm_busy", busy, 0);
    chk("mm_en_after", en, 0);
    @(negedge clk);
    #1 chk("mm_err_pulse", err, 0);
    chk("mm_en_after2", en, 0);

    // Hold for 3 cycles at result 3.
    send(8'd0, 8'd6, 1'b0, 4'd1);
    wait_cnt(8'd3, 30, "hold_reach");
    for (int i = 0; i < 3; i++) begin
      hold = 1'b1;
      #1 chk("hold_en", en, 0);
      chk("hold_result", result, 3);
      @(negedge clk);
    end
    hold = 1'b0;
    #1 chk("resume_result", result, 3);
    chk("resume_en", en, 1);
    chk("resume_dir", dir, 1);
    @(negedge clk);
    #1 chk("resume_next", result, 4);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      #1 if (done) found = 1;
    end
    chk("hold_done_seen", found, 1);

    // Abort while stepping down, infinite repeats.
    send(8'd1, 8'd4, 1'b1, 4'd0);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clk);
      #1 if (en && !dir && !load && busy) found = 1;
    end
    chk("abort_reach_down", found, 1);
    abort = 1'b1;
    #1 chk("abort_en", en, 0);
    @(negedge clk);
    abort = 1'b0;
    #1 chk("abort_state", state, ST_IDLE);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    @(negedge clk);
    #1 chk("abort_done2", done, 0);
    chk("abort_err2", err, 0);

    // Reset in the middle of a 0..255 sweep.
    send(8'd0, 8'd255, 1'b0, 4'd0);
    wait_cnt(8'd100, 200, "rst_reach");
    rst = 1'b1;
    #1 chk("mrst_en", en, 0);
    chk("mrst_dir", dir, 0);
    chk("mrst_load", load, 0);
    chk("mrst_data", data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", cmd_ready, 0);
    @(negedge clk);
    #1 chk("mrst_en2", en, 0);
    chk("mrst_done2", done, 0);
    chk("mrst_err2", err, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mrst_ready_after", cmd_ready, 1);
    chk("mrst_state_after", state, ST_IDLE);

    // Randomized sweeps with random holds.
    for (int k = 0; k < 8; k++) begin
      int lo_v, d_v;
      lo_v = int'($urandom_range(0, 250));
      d_v  = int'($urandom_range(1, 5));
      run_sweep(N'(lo_v), N'(lo_v + d_v), 1'($urandom_range(0, 1)),
                REP_W'($urandom_range(1, 3)), 25);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
